// File: rtl/line_encoder.sv
// Debounced 8-to-3 priority encoder: synchronizes d, commits a stable code/active pair, offers each change as an event.
// Latency: commit 2 + DEBOUNCE_CYCLES edges after the last encoded change. Backpressure: an unaccepted event is overwritten and flags overrun.
module line_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] d,
  input  logic       overrun_clr,
  output logic [2:0] code,
  output logic       active,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [2:0] evt_code,
  output logic       evt_active,
  output logic       overrun
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;
  localparam logic [15:0] NCYC = 16'(DEBOUNCE_CYCLES);

  logic [7:0]  d_s1;
  logic [7:0]  ds;
  logic [2:0]  enc_code;
  logic        enc_act;
  logic [2:0]  cand_code;
  logic        cand_act;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic        load;
  logic [2:0]  cand_code_nxt;
  logic        cand_act_nxt;
  logic        commit;
  logic [0:0]  state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_s1 <= '0;
      ds   <= '0;
    end else begin
      d_s1 <= d;
      ds   <= d_s1;
    end
  end

  always_comb begin
    enc_code = 3'd0;
    enc_act  = |ds;
    for (int i = 0; i < 8; i++) begin
      if (ds[i]) enc_code = 3'(i);
    end
  end

  // Commit fires only on the edge the count reaches NCYC, including the load edge when NCYC is 1.
  always_comb begin
    load          = ({enc_code, enc_act} != {cand_code, cand_act});
    cand_code_nxt = load ? enc_code : cand_code;
    cand_act_nxt  = load ? enc_act  : cand_act;
    if (load)             cnt_nxt = 16'd1;
    else if (cnt < NCYC)  cnt_nxt = cnt + 16'd1;
    else                  cnt_nxt = cnt;
    commit = (cnt_nxt == NCYC) && (load || (cnt != NCYC)) &&
             ({cand_code_nxt, cand_act_nxt} != {code, active});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_code <= '0;
      cand_act  <= 1'b0;
      cnt       <= '0;
      code      <= '0;
      active    <= 1'b0;
    end else begin
      cand_code <= cand_code_nxt;
      cand_act  <= cand_act_nxt;
      cnt       <= cnt_nxt;
      if (commit) begin
        code   <= cand_code_nxt;
        active <= cand_act_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      evt_code   <= '0;
      evt_active <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (commit) begin
        evt_code   <= cand_code_nxt;
        evt_active <= cand_act_nxt;
        state      <= PEND;
      end else if (state == PEND && evt_ready) begin
        state <= IDLE;
      end
      // Set wins over clear when an overwrite lands on the clearing edge.
      if (commit && state == PEND && !evt_ready) overrun <= 1'b1;
      else if (overrun_clr)                      overrun <= 1'b0;
    end
  end

  assign evt_valid = (state == PEND);

endmodule

// File: tb/tb_line_encoder.sv
// Scoreboarded bench for line_encoder: directed scenarios then random traffic against a behavioural model.
module tb_line_encoder;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d = 8'h00;
  logic       overrun_clr = 1'b0;
  logic [2:0] code;
  logic       active;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [2:0] evt_code;
  logic       evt_active;
  logic       overrun;

  int total = 0;
  int bad = 0;

  line_encoder #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .d(d), .overrun_clr(overrun_clr),
    .code(code), .active(active), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_code(evt_code), .evt_active(evt_active), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // {code, active} of the highest set line, zero when no line is set
  function automatic logic [3:0] prio(input logic [7:0] v);
    int hi = -1;
    for (int i = 0; i < 8; i++) if (v[i]) hi = i;
    if (hi < 0) return 4'h0;
    return {3'(hi), 1'b1};
  endfunction

  // Reference model: delay line for the synchronizer, run length of the encoded value, one-slot event queue.
  logic [7:0] m_s1, m_s2;
  logic [3:0] m_last, m_comm;
  int         m_run;
  logic       m_ov;
  logic [3:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    logic [3:0] e;
    logic       ovw;
    if (!rst_n) begin
      m_s1 = 8'h00; m_s2 = 8'h00; m_last = 4'h0; m_comm = 4'h0;
      m_run = 0; m_ov = 1'b0; exp_q.delete();
    end else begin
      ovw = 1'b0;
      e = prio(m_s2);
      m_s2 = m_s1;
      m_s1 = d;
      if (e == m_last) begin
        if (m_run < 100000) m_run++;
      end else begin
        m_run = 1;
      end
      m_last = e;
      if (m_run == N && e != m_comm) begin
        m_comm = e;
        if (exp_q.size() > 0 && !evt_ready) begin
          exp_q[exp_q.size()-1] = e;
          ovw = 1'b1;
        end else begin
          exp_q.push_back(e);
        end
      end
      if (ovw) m_ov = 1'b1;
      else if (overrun_clr) m_ov = 1'b0;
    end
  end

  // Monitor: compares on the falling edge; pops an event when the consumer will accept it at the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("code", {29'd0, code}, {29'd0, m_comm[3:1]});
      chk("active", {31'd0, active}, {31'd0, m_comm[0]});
      chk("evt_valid", {31'd0, evt_valid}, {31'd0, exp_q.size() > 0});
      chk("overrun", {31'd0, overrun}, {31'd0, m_ov});
      if (exp_q.size() > 0) begin
        chk("evt_fields", {28'd0, evt_code, evt_active}, {28'd0, exp_q[0]});
        if (evt_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {24'd0, code, active, evt_valid, evt_code, evt_active, overrun}, 32'd0);
  endtask

  initial begin
    #1;
    chk_all_zero("reset_outputs");
    step(3);
    rst_n = 1'b1;
    step(5);

    // Basic commit and latency
    d = 8'h01;
    step(5);
    chk("lat_before", {31'd0, evt_valid}, 32'd0);
    step(1);
    chk("lat_commit", {27'd0, code, active, evt_valid}, {27'd0, 3'd0, 1'b1, 1'b1});
    chk("lat_evt", {28'd0, evt_code, evt_active}, {28'd0, 3'd0, 1'b1});
    evt_ready = 1'b1; step(1); evt_ready = 1'b0;
    chk("accept_drop", {31'd0, evt_valid}, 32'd0);

    // Priority
    evt_ready = 1'b1;
    d = 8'hA0; step(8);
    chk("prio_a0", {29'd0, code}, 32'd7);
    d = 8'h20; step(8);
    chk("prio_20", {29'd0, code}, 32'd5);
    evt_ready = 1'b0;
    d = 8'h00; step(8);
    chk("prio_zero", {28'd0, code, active}, 32'd0);
    chk("zero_evt", {30'd0, evt_valid, evt_active}, {30'd0, 1'b1, 1'b0});
    evt_ready = 1'b1; step(1); evt_ready = 1'b0;

    // Glitch rejection
    d = 8'h08; step(2);
    d = 8'h00; step(10);
    chk("glitch", {30'd0, active, evt_valid}, 32'd0);

    // Lower-priority toggling does not restart the count
    d = 8'h80;
    for (int i = 0; i < 5; i++) begin
      step(1);
      d = d ^ 8'h02;
    end
    chk("toggle_early", {31'd0, active}, 32'd0);
    step(1);
    d = d ^ 8'h02;
    chk("toggle_commit", {28'd0, code, active}, {28'd0, 3'd7, 1'b1});
    step(4);
    evt_ready = 1'b1; step(1); evt_ready = 1'b0;

    // Overrun
    d = 8'h01; step(10);
    d = 8'h04; step(10);
    chk("ovr_code", {29'd0, evt_code}, 32'd2);
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    overrun_clr = 1'b1; step(1); overrun_clr = 1'b0;
    chk("ovr_clr", {30'd0, overrun, evt_valid}, {30'd0, 1'b0, 1'b1});

    // Accept on the same edge as a new commit
    d = 8'h10; step(5);
    evt_ready = 1'b1; step(1); evt_ready = 1'b0;
    chk("simul", {27'd0, evt_valid, evt_code, overrun}, {27'd0, 1'b1, 3'd4, 1'b0});
    evt_ready = 1'b1; step(1); evt_ready = 1'b0;

    // Reset mid-cycle while an event is pending
    d = 8'hFF; step(10);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    d = 8'h00;
    step(2);
    rst_n = 1'b1;
    step(20);
    chk("post_reset", {31'd0, evt_valid}, 32'd0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      int hold;
      case ($urandom_range(0, 3))
        0: d = 8'h00;
        1: d = 8'(1 << $urandom_range(0, 7));
        default: d = 8'($urandom);
      endcase
      hold = $urandom_range(1, 9);
      for (int j = 0; j < hold; j++) begin
        evt_ready   = ($urandom_range(0, 3) == 0);
        overrun_clr = ($urandom_range(0, 15) == 0);
        step(1);
      end
    end
    evt_ready = 1'b0; overrun_clr = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_encoder.md
# line_encoder

Debounced 8-to-3 priority encoder with an event handshake; it is the encode-side counterpart of the board's 3-to-8 select/enable demultiplexer. It samples eight asynchronous lines (switches or buttons), synchronizes and debounces the encoded result, and presents a registered code. Its 3-bit code/active pair maps directly onto a demux's select (a = bit 0, b = bit 1, c = bit 2) and enable inputs. Every debounced change is also offered to a downstream consumer through a valid/ready event port.

## Interface
- DEBOUNCE_CYCLES, 16, consecutive clock edges an encoded value must stay stable before commit; legal range 1..65535.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- d  input  8  asynchronous request lines; bit i set = line i active.
- overrun_clr  input  1  synchronous clear of overrun.
- code  output  3  committed index of highest set line (bit0 ↔ a, bit1 ↔ b, bit2 ↔ c).
- active  output  1  committed "any line set" (↔ demux enable e).
- evt_valid  output  1  event pending.
- evt_ready  input  1  consumer accepts event.
- evt_code  output  3  code carried by pending event.
- evt_active  output  1  active carried by pending event.
- overrun  output  1  sticky: an unaccepted event was overwritten.

## Operation
- Synchronizer: two flops per bit on d, giving ds. Reset value is 0.
- Encoder (combinational on ds): enc_act = |ds. enc_code = index of the highest set bit of ds. enc_code = 0 when ds = 0.
- Debouncer: holds a candidate {cand_code, cand_act} and a 16-bit counter cnt.
  - If {enc_code, enc_act} ≠ candidate: load the candidate and set cnt = 1.
  - Else if cnt < DEBOUNCE_CYCLES: cnt increments. cnt saturates at DEBOUNCE_CYCLES.
- Commit: occurs on the edge where cnt becomes DEBOUNCE_CYCLES. This includes the load edge itself when DEBOUNCE_CYCLES = 1.
  - If the candidate ≠ {code, active}, it is written to code/active and a commit event fires.
  - If the candidate equals the committed value, nothing happens. A glitch that returns to the old value produces no event.
- Event FSM, two states:
  - IDLE: evt_valid = 0. On a commit event: load evt_code/evt_active from the new value and go to PEND.
  - PEND: evt_valid = 1. evt_code/evt_active are held stable.
    - evt_ready = 1 with no commit: go to IDLE.
    - evt_ready = 1 with a commit on the same edge: the handshake completes, the new event loads, and the state stays PEND. overrun is not set.
    - evt_ready = 0 with a commit: evt fields are overwritten with the newest value, the state stays PEND, and overrun is set to 1.
- overrun: cleared on the edge where overrun_clr = 1, unless an overwrite occurs on that same edge; set wins.
- evt_ready is ignored in IDLE.

## Timing
- Reset (rst_n = 0, asynchronous): the following take effect immediately and are held while rst_n = 0.
  - code = 0, active = 0, evt_valid = 0, evt_code = 0, evt_active = 0, overrun = 0.
  - Sync flops, candidate, and cnt are cleared. FSM is in IDLE.
- Reset mid-operation discards any pending event and partial debounce count. After release, the block behaves as from power-up.
- Latency: count the first edge that samples the new d as edge 1. code/active and evt_valid update after edge 2 + DEBOUNCE_CYCLES, provided ds is stable from edge 2 on. Example: DEBOUNCE_CYCLES = 4 gives edge 6.
- Any change of the encoded value before commit restarts the count at 1. Total latency is measured from the last change.
- Changes of d that leave {enc_code, enc_act} unchanged do not restart the count. Example: a lower-priority bit toggling while a higher one is held.
- evt_valid deasserts on the edge after it is accepted: sampled evt_valid = 1 and evt_ready = 1 at an edge, unless a commit occurs on that same edge.
- Max throughput: one event per DEBOUNCE_CYCLES edges.

## Test plan
- Reset: rst_n = 0 asserted mid-cycle with d = 8'hFF and the FSM in PEND.
  - Expected: all outputs 0 immediately.
  - After release with d = 0: outputs stay 0 and no event occurs.
- Basic commit (DEBOUNCE_CYCLES = 4, evt_ready = 0): d goes 0 → 8'h01.
  - After edge 6: code = 0, active = 1, evt_valid = 1, evt_code = 0, evt_active = 1.
  - Then evt_ready = 1 for one edge: evt_valid = 0 after that edge.
- Priority: d = 8'hA0.
  - Expected: code = 7.
  - Then d = 8'h20: code = 5 after 2 + N edges.
  - Then d = 0: code = 0, active = 0, and an event with evt_active = 0.
- Glitch rejection (N = 4): from d = 0, pulse d = 8'h08 for 2 cycles.
  - Expected: code and active unchanged, evt_valid stays 0.
  - Also: 8'h80 held with bit 1 toggling each cycle → commits code = 7 on schedule.
- Overrun: evt_ready = 0; d steps 8'h01 → 8'h04, each step held 10 cycles.
  - Expected: evt_code = 2, overrun = 1.
  - overrun_clr = 1 for one edge → overrun = 0, evt_valid still 1.
- Simultaneous: evt_ready = 1 on the exact commit edge of a second change while PEND.
  - Expected: evt_valid stays 1 with the new code and overrun stays 0.
